// File: rtl/jtframe_sdram_bram_resp.sv
// Block-RAM backed responder for the JTFRAME SDRAM request interface.
// Answers rd/wr requests with the SDRAM controller handshake
// (ack, then dst for reads, then rdy) after a configurable latency,
// and periodically stalls for a configurable refresh window.
module jtframe_sdram_bram_resp #(
    parameter int SDRAMW         = 12,
    parameter int LATENCY        = 3,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_LEN    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_rd,
    input  logic              sdram_wr,
    input  logic [SDRAMW-1:0] sdram_addr,
    input  logic [15:0]       data_write,
    input  logic [1:0]        sdram_wrmask,
    output logic              sdram_ack,
    output logic              data_dst,
    output logic              data_rdy,
    output logic [15:0]       data_read,
    output logic              busy,
    output logic              refresh
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REFRESH
    } state_t;

    localparam int RCW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int LW  = (REFRESH_LEN > 1) ? $clog2(REFRESH_LEN) : 1;

    localparam logic [RCW-1:0] RC_LAST  = RCW'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
    localparam logic [LW-1:0]  LEN_LAST = LW'(REFRESH_LEN - 1);
    localparam logic [3:0]     LAT_LOAD = 4'(LATENCY - 1);

    logic [15:0]       mem [0:(2**SDRAMW)-1];
    logic [15:0]       mem_q;
    state_t            state;
    logic [3:0]        lat_cnt;
    logic [LW-1:0]     ref_cnt;
    logic [RCW-1:0]    rc;
    logic              pending;
    logic              op_rd;
    logic              accept;
    logic [SDRAMW-1:0] addr_q;

    // A request is taken only from IDLE when no refresh is waiting
    always_comb begin
        accept = (state == ST_IDLE) && !pending && (sdram_rd || sdram_wr);
    end

    // Backing store: byte-masked write on acceptance, registered read of the latched address
    always_ff @(posedge clk) begin
        if (accept && sdram_wr) begin
            if (!sdram_wrmask[1]) mem[sdram_addr][15:8] <= data_write[15:8];
            if (!sdram_wrmask[0]) mem[sdram_addr][7:0]  <= data_write[7:0];
        end
        mem_q <= mem[addr_q];
    end

    // Free-running refresh timer; a wrap raises a single pending flag (extra wraps are lost)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc      <= '0;
            pending <= 1'b0;
        end else if (REFRESH_PERIOD == 0) begin
            rc      <= '0;
            pending <= 1'b0;
        end else begin
            if (rc == RC_LAST) begin
                rc      <= '0;
                pending <= 1'b1;
            end else begin
                rc <= rc + 1'b1;
                if (state == ST_IDLE && pending) pending <= 1'b0;
            end
        end
    end

    // Handshake FSM with registered pulses and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sdram_ack <= 1'b0;
            data_dst  <= 1'b0;
            data_rdy  <= 1'b0;
            busy      <= 1'b0;
            refresh   <= 1'b0;
            data_read <= '0;
            lat_cnt   <= '0;
            ref_cnt   <= '0;
            addr_q    <= '0;
            op_rd     <= 1'b0;
        end else begin
            sdram_ack <= 1'b0;
            data_dst  <= 1'b0;
            data_rdy  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state   <= ST_REFRESH;
                        ref_cnt <= LEN_LAST;
                        busy    <= 1'b1;
                        refresh <= 1'b1;
                    end else if (accept) begin
                        state     <= ST_WAIT;
                        sdram_ack <= 1'b1;
                        op_rd     <= !sdram_wr;
                        addr_q    <= sdram_addr;
                        lat_cnt   <= LAT_LOAD;
                        busy      <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == 4'd1 && op_rd) data_dst <= 1'b1;
                    if (lat_cnt == 4'd0) begin
                        data_rdy <= 1'b1;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        if (op_rd) data_read <= mem_q;
                    end
                end
                ST_REFRESH: begin
                    ref_cnt <= ref_cnt - 1'b1;
                    if (ref_cnt == '0) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        refresh <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
